// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and arbiter FSM encoding.
package wb_pkg;
  localparam int WB_ADR_W = 20;
  localparam int WB_DAT_W = 16;
  localparam int WB_SEL_W = 2;
  localparam int NUM_M    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } wb_arb_state_e;
endpackage

// File: rtl/wb_rr_pick.sv
// Rotating priority encoder: first requester after last_i wins (combinational).
module wb_rr_pick
  import wb_pkg::*;
(
  input  logic [NUM_M-1:0] req_i,
  input  logic [1:0]       last_i,
  output logic [1:0]       win_o,
  output logic             vld_o
);
  logic [1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest one sticks.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      idx = last_i + 2'(k);
      if (req_i[idx]) begin
        win_o = idx;
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Four-master Wishbone arbiter, one owner per cyc, RR or fixed priority.
// Define WB_ARB_TIMEOUT_EN to build the slave-stall watchdog.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int TOUT_CYCLES = 255,
  parameter int RR_EN       = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [WB_ADR_W:1]   m0_adr_i,
  input  logic [WB_ADR_W:1]   m1_adr_i,
  input  logic [WB_ADR_W:1]   m2_adr_i,
  input  logic [WB_ADR_W:1]   m3_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  input  logic [WB_DAT_W-1:0] m2_dat_i,
  input  logic [WB_DAT_W-1:0] m3_dat_i,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic [WB_DAT_W-1:0] m2_dat_o,
  output logic [WB_DAT_W-1:0] m3_dat_o,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  input  logic [WB_SEL_W-1:0] m2_sel_i,
  input  logic [WB_SEL_W-1:0] m3_sel_i,
  input  logic                m0_we_i,
  input  logic                m1_we_i,
  input  logic                m2_we_i,
  input  logic                m3_we_i,
  input  logic                m0_cyc_i,
  input  logic                m1_cyc_i,
  input  logic                m2_cyc_i,
  input  logic                m3_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m1_stb_i,
  input  logic                m2_stb_i,
  input  logic                m3_stb_i,
  output logic                m0_ack_o,
  output logic                m1_ack_o,
  output logic                m2_ack_o,
  output logic                m3_ack_o,
  output logic [WB_ADR_W:1]   s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  input  logic                s_ack_i,
  output logic [1:0]          gnt_o,
  output logic                gnt_vld_o,
  output logic                tout_o
);
  logic [NUM_M-1:0]                cyc, stb, we, ack_v;
  logic [NUM_M-1:0][WB_ADR_W-1:0]  adr;
  logic [NUM_M-1:0][WB_DAT_W-1:0]  wdat;
  logic [NUM_M-1:0][WB_SEL_W-1:0]  sel;
  logic [WB_DAT_W-1:0]             rdat;

  wb_arb_state_e state_q, state_d;
  logic [1:0]    gnt_q, gnt_d, last_q, last_d;
  logic [1:0]    pick_win, pick_last;
  logic          pick_vld, owned, tout;

  assign cyc  = {m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign stb  = {m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};
  assign we   = {m3_we_i,  m2_we_i,  m1_we_i,  m0_we_i};
  assign adr  = {m3_adr_i, m2_adr_i, m1_adr_i, m0_adr_i};
  assign wdat = {m3_dat_i, m2_dat_i, m1_dat_i, m0_dat_i};
  assign sel  = {m3_sel_i, m2_sel_i, m1_sel_i, m0_sel_i};

  // Fixed priority is RR with the search pinned to start at m0.
  assign pick_last = (RR_EN != 0) ? last_q : 2'd3;

  wb_rr_pick u_pick (
    .req_i  (cyc),
    .last_i (pick_last),
    .win_o  (pick_win),
    .vld_o  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        state_d = ST_OWNED;
        gnt_d   = pick_win;
        last_d  = pick_win;
      end
      ST_OWNED: if (!cyc[gnt_q]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign owned = (state_q == ST_OWNED);

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign tout = owned & cyc[gnt_q] & stb[gnt_q] & (cnt_q == 8'(TOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (!owned || s_ack_i || tout) cnt_d = '0;
    else if (s_stb_o)              cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  // Watchdog compiled out; the limit parameter is intentionally unused here.
  logic unused_tout;
  assign unused_tout = ^8'(TOUT_CYCLES);
  assign tout        = 1'b0;
`endif

  assign s_adr_o = adr[gnt_q];
  assign s_dat_o = wdat[gnt_q];
  assign s_sel_o = sel[gnt_q];
  assign s_we_o  = we[gnt_q];
  assign s_cyc_o = owned & cyc[gnt_q];
  assign s_stb_o = owned & stb[gnt_q] & ~tout;

  always_comb begin
    ack_v = '0;
    if (owned && (s_ack_i || tout)) ack_v[gnt_q] = 1'b1;
  end

  assign {m3_ack_o, m2_ack_o, m1_ack_o, m0_ack_o} = ack_v;

  assign rdat     = tout ? '1 : s_dat_i;
  assign m0_dat_o = rdat;
  assign m1_dat_o = rdat;
  assign m2_dat_o = rdat;
  assign m3_dat_o = rdat;

  assign gnt_o     = gnt_q;
  assign gnt_vld_o = owned;
  assign tout_o    = tout;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: an RR instance and a fixed-priority instance, each
// checked every cycle against a transaction-level ownership model.
module tb_wb_arbiter;
  localparam int TO = 16;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][3:0]        cyc, stb, ack;
  logic [3:0][19:0]       adr;
  logic [3:0][15:0]       wdat;
  logic [3:0][1:0]        sel;
  logic [3:0]             we;
  logic [15:0]            sdat;
  logic [1:0]             sack;
  logic [1:0][3:0][15:0]  mdo;
  logic [1:0][19:0]       sadr;
  logic [1:0][15:0]       sdo;
  logic [1:0][1:0]        ssel, gnt;
  logic [1:0]             swe, scyc, sstb, gvld, tout;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    wb_arbiter #(.TOUT_CYCLES(TO), .RR_EN(d == 0 ? 1 : 0)) u_dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m0_adr_i(adr[0]), .m1_adr_i(adr[1]), .m2_adr_i(adr[2]), .m3_adr_i(adr[3]),
      .m0_dat_i(wdat[0]), .m1_dat_i(wdat[1]), .m2_dat_i(wdat[2]), .m3_dat_i(wdat[3]),
      .m0_dat_o(mdo[d][0]), .m1_dat_o(mdo[d][1]), .m2_dat_o(mdo[d][2]), .m3_dat_o(mdo[d][3]),
      .m0_sel_i(sel[0]), .m1_sel_i(sel[1]), .m2_sel_i(sel[2]), .m3_sel_i(sel[3]),
      .m0_we_i(we[0]), .m1_we_i(we[1]), .m2_we_i(we[2]), .m3_we_i(we[3]),
      .m0_cyc_i(cyc[d][0]), .m1_cyc_i(cyc[d][1]), .m2_cyc_i(cyc[d][2]), .m3_cyc_i(cyc[d][3]),
      .m0_stb_i(stb[d][0]), .m1_stb_i(stb[d][1]), .m2_stb_i(stb[d][2]), .m3_stb_i(stb[d][3]),
      .m0_ack_o(ack[d][0]), .m1_ack_o(ack[d][1]), .m2_ack_o(ack[d][2]), .m3_ack_o(ack[d][3]),
      .s_adr_o(sadr[d]), .s_dat_o(sdo[d]), .s_sel_o(ssel[d]), .s_we_o(swe[d]),
      .s_cyc_o(scyc[d]), .s_stb_o(sstb[d]), .s_dat_i(sdat), .s_ack_i(sack[d]),
      .gnt_o(gnt[d]), .gnt_vld_o(gvld[d]), .tout_o(tout[d])
    );
  end

  int nvec = 0, nerr = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave: registered ack after lat stb cycles (lat 0 = never acks).
  int lat[2];
  int wcnt[2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sack <= '0;
      for (int d = 0; d < 2; d++) wcnt[d] <= 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (sack[d]) begin
          sack[d] <= 1'b0; wcnt[d] <= 0;
        end else if (sstb[d] && lat[d] > 0) begin
          if (wcnt[d] + 1 >= lat[d]) begin sack[d] <= 1'b1; wcnt[d] <= 0; end
          else wcnt[d] <= wcnt[d] + 1;
        end else wcnt[d] <= 0;
      end
    end
  end

  // Ownership model: who holds the bus, last winner, stall count.
  bit m_own[2];
  int m_owner[2], m_last[2], m_cnt[2];

  function automatic bit exp_tout(input int d);
    int o = m_owner[d];
    return TEN && m_own[d] && cyc[d][o] && stb[d][o] && (m_cnt[d] == TO);
  endfunction

  function automatic int pick(input int d);
    if (d == 0) begin
      for (int k = 1; k <= 4; k++) if (cyc[d][(m_last[d] + k) % 4]) return (m_last[d] + k) % 4;
    end else begin
      for (int i = 0; i < 4; i++) if (cyc[d][i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_own[d] <= 1'b0; m_owner[d] <= 0; m_last[d] <= 3; m_cnt[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!m_own[d]) begin
          if (cyc[d] != 4'b0) begin
            m_own[d] <= 1'b1; m_owner[d] <= pick(d); m_last[d] <= pick(d);
          end
          m_cnt[d] <= 0;
        end else begin
          if (!cyc[d][m_owner[d]]) m_own[d] <= 1'b0;
          if (!TEN || sack[d] || exp_tout(d)) m_cnt[d] <= 0;
          else if (stb[d][m_owner[d]]) m_cnt[d] <= m_cnt[d] + 1;
        end
      end
    end
  end

  task automatic compare(input int d);
    int o;
    bit t;
    logic [7:0] e;
    o = m_owner[d];
    t = exp_tout(d);
    e = '0;
    e[7] = m_own[d];
    e[6] = m_own[d] && cyc[d][o];
    e[5] = m_own[d] && stb[d][o] && !t;
    for (int n = 0; n < 4; n++) e[1+n] = m_own[d] && (n == o) && (sack[d] || t);
    e[0] = t;
    check($sformatf("ctl%0d", d), {gvld[d], scyc[d], sstb[d], ack[d], tout[d]}, e);
    if (m_own[d])
      check($sformatf("mux%0d", d), {gnt[d], sadr[d], sdo[d], ssel[d], swe[d]},
            {2'(o), adr[o], wdat[o], sel[o], we[o]});
    check($sformatf("rdat%0d", d), mdo[d], t ? {4{16'hFFFF}} : {4{sdat}});
  endtask

  // Bus-functional masters: rounds of cyc, each carrying xpr acked transfers.
  int rem[2][4], rounds[2][4], xpr[2][4];
  int gq0[$], gq1[$], gap0[$];
  int idle0 = 99;
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic s_gvld, s_scyc, s_sstb, s_tout;
  logic [1:0] s_gnt;
  logic [3:0] s_ack;
  logic [15:0] s_mdo;
  logic [19:0] s_sadr;

  task automatic bfm();
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 4; n++) begin
        if (cyc[d][n]) begin
          if (ack[d][n]) begin
            rem[d][n]--;
            if (rem[d][n] == 0) begin cyc[d][n] = 1'b0; stb[d][n] = 1'b0; rounds[d][n]--; end
          end
        end else if (rounds[d][n] > 0) begin
          cyc[d][n] = 1'b1; stb[d][n] = 1'b1; rem[d][n] = xpr[d][n];
        end
      end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare(0);
    compare(1);
    s_gvld = gvld[0]; s_gnt = gnt[0]; s_scyc = scyc[0]; s_sstb = sstb[0];
    s_ack = ack[0]; s_tout = tout[0]; s_mdo = mdo[0][0]; s_sadr = sadr[0];
    if (gvld[0] && !pv0) begin gq0.push_back(int'(gnt[0])); gap0.push_back(idle0); end
    if (gvld[1] && !pv1) gq1.push_back(int'(gnt[1]));
    idle0 = gvld[0] ? 0 : idle0 + 1;
    pv0 = gvld[0];
    pv1 = gvld[1];
    bfm();
    sdat = sdat + 16'h0123;
  endtask

  function automatic bit busy();
    bit b = (cyc != '0) || (gvld != '0);
    for (int d = 0; d < 2; d++) for (int n = 0; n < 4; n++) if (rounds[d][n] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_idle(input string nm, input int budget);
    int n = 0;
    while (busy() && n < budget) begin cycle(); n++; end
    check({nm, " completes"}, 64'(busy()), 64'd0);
  endtask

  task automatic clear_bfm();
    cyc = '0; stb = '0;
    for (int d = 0; d < 2; d++) for (int n = 0; n < 4; n++) begin
      rem[d][n] = 0; rounds[d][n] = 0; xpr[d][n] = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bfm();
    lat[0] = 1; lat[1] = 1;
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    gq0.delete(); gq1.delete(); gap0.delete();
    idle0 = 99;
  endtask

  // Grant sequence as hex digits of (index+1), so m0 shows as 1.
  function automatic logic [63:0] code(input int q[$]);
    logic [63:0] c = '0;
    foreach (q[i]) c = (c << 4) | 64'(q[i] + 1);
    return c;
  endfunction

  int a2, ao, a0, ntout, stalls, tstall, acks, bad;
  logic [15:0] tdat;

  initial begin
    adr  = {20'hFFFFF, 20'h0A000, 20'h5A5A5, 20'h01234};
    wdat = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    sel  = {2'b00, 2'b11, 2'b10, 2'b01};
    we   = 4'b0101;
    sdat = 16'hC0DE;
    lat[0] = 1; lat[1] = 1;
    clear_bfm();

    // reset state
    cycle();
    check("rst gnt", gnt, '0);
    check("rst gvld/tout", {gvld, tout}, '0);
    check("rst s_cyc/s_stb", {scyc, sstb}, '0);
    cycle();
    #2 rst_n = 1'b1;

    // single m2 transfer, slave acks after 3 stall cycles
    lat[0] = 3; rounds[0][2] = 1;
    cycle();
    cycle();
    check("single gnt", {s_gvld, s_gnt}, 3'b110);
    check("single adr", s_sadr, 20'h0A000);
    a2 = 0; ao = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      a2 += int'(s_ack[2]);
      ao += int'(|(s_ack & 4'b1011));
    end
    check("single m2 acks", a2, 1);
    check("single other acks", ao, 0);
    run_idle("single", 50);

    // four-way contention, m0 comes back for a second cycle
    do_reset();
    rounds[0][0] = 2; rounds[0][1] = 1; rounds[0][2] = 1; rounds[0][3] = 1;
    run_idle("rr", 300);
    check("rr order", code(gq0), 64'h12341);
    bad = 0;
    for (int i = 1; i < gap0.size(); i++) if (gap0[i] != 1) bad++;
    check("rr idle gaps", bad, 0);

    // m1 (twice) and m3 together, on both arbitration modes
    do_reset();
    for (int d = 0; d < 2; d++) begin rounds[d][1] = 2; rounds[d][3] = 1; end
    run_idle("pair", 300);
    check("rr pair order", code(gq0), 64'h242);
    check("fixed order", code(gq1), 64'h224);

    // burst lock: m0 does 4 transfers in one cyc while m1 waits
    do_reset();
    lat[0] = 2; rounds[0][0] = 1; xpr[0][0] = 4; rounds[0][1] = 1;
    a0 = 0;
    for (int i = 0; i < 200 && busy(); i++) begin
      cycle();
      if (s_gvld && s_gnt == 2'd0) a0 += int'(s_ack[0]);
    end
    check("burst completes", 64'(busy()), 64'd0);
    check("burst m0 acks", a0, 4);
    check("burst order", code(gq0), 64'h12);

    // stalled slave
    do_reset();
    lat[0] = 0; rounds[0][0] = 1;
    ntout = 0; stalls = 0; tstall = -1; acks = 0; tdat = '0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (s_tout) begin ntout++; tstall = stalls; tdat = s_mdo; end
      else if (s_gvld && s_sstb && !s_ack[0]) stalls++;
      acks += int'(s_ack[0]);
    end
    if (TEN) begin
      check("tout pulses", ntout, 1);
      check("tout stall cycles", tstall, TO);
      check("tout rdat", tdat, 16'hFFFF);
      check("tout acks", acks, 1);
    end else begin
      check("no tout", ntout, 0);
      check("no ack", acks, 0);
      check("stall holds", s_gvld, 1'b1);
      clear_bfm();
    end
    run_idle("tout", 50);

    // reset during an m1 transfer, then m0 and m1 compete
    do_reset();
    lat[0] = 0; rounds[0][1] = 1;
    cycle();
    cycle();
    cycle();
    check("pre-reset owner", {s_gvld, s_gnt}, 3'b101);
    #2 rst_n = 1'b0;
    lat[0] = 1; rounds[0][0] = 1;
    gq0.delete();
    #1 check("reset aborts", {scyc[0], sstb[0], gvld[0]}, 3'b000);
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    run_idle("post-reset", 100);
    check("post-reset order", code(gq0), 64'h12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1);
  end
endmodule
